// File: rtl/clock_setup_pkg.sv
// rtl/clock_setup_pkg.sv - shared types, field limits and wrap helper for the time-setting controller
// Purpose: state and field enumerations, per-field maximum values, and the
//          saturate-then-wrap step function used when editing a field.
// Ports:   none (package)
package clock_setup_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HOUR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT_HOUR,
        COMMIT_MIN,
        COMMIT_SEC
    } state_t;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HOUR = 2'd1,
        FLD_MIN  = 2'd2,
        FLD_SEC  = 2'd3
    } field_t;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] SEC_MAX  = 8'd59;

    // A captured value above the field maximum came from a corrupt counter;
    // it is treated as the maximum before stepping so the user can recover.
    function automatic logic [7:0] step_field(input logic [7:0] value,
                                              input logic [7:0] max,
                                              input logic       up);
        logic [7:0] v;
        v = (value > max) ? max : value;
        if (up) begin
            step_field = (v == max) ? 8'd0 : v + 8'd1;
        end else begin
            step_field = (v == 8'd0) ? max : v - 8'd1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, level filter and press pulse generator
// Purpose: brings a raw asynchronous button into the clock domain, accepts a new
//          level only after it has been stable for DEBOUNCE_CYCLES cycles, and
//          emits a one-cycle press pulse the cycle after the accepted level rises.
// Ports:   clock  - system clock
//          reset  - asynchronous, active-low
//          raw    - raw active-high button
//          level  - debounced accepted level
//          press  - one-cycle pulse after a rising accepted level
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        level_d;
    logic [31:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // cnt counts consecutive cycles the synchronized input disagrees
            // with the accepted level; any agreement restarts the count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYCLES - 1) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/clock_setup_ctrl.sv
// rtl/clock_setup_ctrl.sv - button-driven hh:mm:ss time-setting controller
// Purpose: snapshots the live counters, lets the user edit hour/min/sec with
//          MODE/UP/DOWN (with auto-repeat), then loads the result through a
//          three-cycle one-hot strobe sequence. Holds the counters while editing
//          and aborts without loading after an inactivity timeout.
// Ports:   clock, reset               - system clock, asynchronous active-low reset
//          btn_mode, btn_up, btn_down - raw active-high buttons
//          cur_hour, cur_min, cur_sec - live counter values
//          setup_imp                  - one-hot load strobe [2]=hour [1]=min [0]=sec
//          setup_data                 - load value while a strobe is high
//          run_en                     - counter enable, low while editing/committing
//          edit_field                 - field being edited (0 none, 1 h, 2 m, 3 s)
//          blink                      - highlight blink while editing
module clock_setup_ctrl
    import clock_setup_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000,
    parameter int unsigned BLINK_HALF      = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [2:0] setup_imp,
    output logic [7:0] setup_data,
    output logic       run_en,
    output logic [1:0] edit_field,
    output logic       blink
);

    logic        mode_level_unused;
    logic        mode_press;
    logic [1:0]  lvl;           // [0]=up, [1]=down accepted levels
    logic [1:0]  prs;           // [0]=up, [1]=down press pulses
    logic [1:0]  rep;           // [0]=up, [1]=down auto-repeat pulses
    logic [31:0] rep_cnt [2];

    state_t      state;
    logic [7:0]  edit_h;
    logic [7:0]  edit_m;
    logic [7:0]  edit_s;
    logic [31:0] idle_cnt;
    logic [31:0] blink_cnt;

    logic        step_up;
    logic        step_dn;
    logic        do_step;
    logic        any_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clock (clock),
        .reset (reset),
        .raw   (btn_mode),
        .level (mode_level_unused),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clock (clock),
        .reset (reset),
        .raw   (btn_up),
        .level (lvl[0]),
        .press (prs[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clock (clock),
        .reset (reset),
        .raw   (btn_down),
        .level (lvl[1]),
        .press (prs[1])
    );

    // rep_cnt holds the number of cycles since the press pulse. After the first
    // repeat it is rewound so the next hit of REPEAT_DELAY-1 is REPEAT_PERIOD
    // cycles later (assumes REPEAT_DELAY >= REPEAT_PERIOD).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                rep_cnt[i] <= '0;
            end
            rep <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep[i] <= 1'b0;
                if (!lvl[i]) begin
                    rep_cnt[i] <= '0;
                end else if (prs[i]) begin
                    rep_cnt[i] <= 32'd1;
                end else if (rep_cnt[i] == REPEAT_DELAY - 1) begin
                    rep[i]     <= 1'b1;
                    rep_cnt[i] <= REPEAT_DELAY - REPEAT_PERIOD;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign step_up   = prs[0] | rep[0];
    assign step_dn   = prs[1] | rep[1];
    assign do_step   = step_up ^ step_dn;   // both at once cancel out
    assign any_press = mode_press | prs[0] | prs[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            setup_imp  <= '0;
            setup_data <= '0;
            run_en     <= 1'b1;
            edit_field <= FLD_NONE;
            blink      <= 1'b0;
            edit_h     <= '0;
            edit_m     <= '0;
            edit_s     <= '0;
            idle_cnt   <= '0;
            blink_cnt  <= '0;
        end else begin
            setup_imp  <= '0;
            setup_data <= '0;

            if (state inside {EDIT_HOUR, EDIT_MIN, EDIT_SEC}) begin
                if (blink_cnt == BLINK_HALF - 1) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 32'd1;
                end
                idle_cnt <= any_press ? 32'd0 : idle_cnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (mode_press) begin
                        state      <= EDIT_HOUR;
                        edit_h     <= cur_hour;
                        edit_m     <= cur_min;
                        edit_s     <= cur_sec;
                        run_en     <= 1'b0;
                        edit_field <= FLD_HOUR;
                        blink      <= 1'b0;
                        blink_cnt  <= '0;
                        idle_cnt   <= '0;
                    end
                end
                EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
                    if (mode_press) begin
                        case (state)
                            EDIT_HOUR: begin
                                state      <= EDIT_MIN;
                                edit_field <= FLD_MIN;
                            end
                            EDIT_MIN: begin
                                state      <= EDIT_SEC;
                                edit_field <= FLD_SEC;
                            end
                            default: begin
                                state      <= COMMIT_HOUR;
                                setup_imp  <= 3'b100;
                                setup_data <= edit_h;
                                blink      <= 1'b0;
                            end
                        endcase
                    end else if (!any_press && idle_cnt == TIMEOUT_CYCLES - 1) begin
                        // Abandon the edit; counters resume from their own values.
                        state      <= IDLE;
                        run_en     <= 1'b1;
                        edit_field <= FLD_NONE;
                        blink      <= 1'b0;
                    end else if (do_step) begin
                        case (state)
                            EDIT_HOUR: edit_h <= step_field(edit_h, HOUR_MAX, step_up);
                            EDIT_MIN:  edit_m <= step_field(edit_m, MIN_MAX, step_up);
                            default:   edit_s <= step_field(edit_s, SEC_MAX, step_up);
                        endcase
                    end
                end
                COMMIT_HOUR: begin
                    state      <= COMMIT_MIN;
                    setup_imp  <= 3'b010;
                    setup_data <= edit_m;
                end
                COMMIT_MIN: begin
                    state      <= COMMIT_SEC;
                    setup_imp  <= 3'b001;
                    setup_data <= edit_s;
                end
                COMMIT_SEC: begin
                    state      <= IDLE;
                    run_en     <= 1'b1;
                    edit_field <= FLD_NONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_setup_ctrl.sv
// tb/tb_clock_setup_ctrl.sv - self-checking bench for clock_setup_ctrl
module tb_clock_setup_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned RDLY = 20;
    localparam int unsigned RPER = 5;
    localparam int unsigned TMO  = 200;
    localparam int unsigned BLK  = 8;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] cur_hour = 8'd0;
    logic [7:0] cur_min  = 8'd0;
    logic [7:0] cur_sec  = 8'd0;
    logic [2:0] setup_imp;
    logic [7:0] setup_data;
    logic       run_en;
    logic [1:0] edit_field;
    logic       blink;

    int total = 0;
    int bad   = 0;

    clock_setup_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER),
        .TIMEOUT_CYCLES  (TMO),
        .BLINK_HALF      (BLK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .setup_imp  (setup_imp),
        .setup_data (setup_data),
        .run_en     (run_en),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int         cyc;
        logic [2:0] imp;
        logic [7:0] data;
        logic       run;
    } stb_t;

    stb_t       q[$];
    int         cyc        = 0;
    int         run_after  = -1;
    int         run_falls  = 0;
    logic [2:0] prev_imp   = 3'b000;
    logic       prev_run   = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (setup_imp != 3'b000) q.push_back('{cyc, setup_imp, setup_data, run_en});
        if (prev_imp == 3'b001) run_after = int'(run_en);
        if (prev_run && !run_en) run_falls++;
        prev_imp = setup_imp;
        prev_run = run_en;
    end

    typedef struct {
        logic [7:0] ch, cm, cs;
        int         dh, dm, ds;
        logic [7:0] eh, em, es;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        tick(8);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        q.delete();
        run_after = -1;
        run_falls = 0;
    endtask

    task automatic steps(input int d);
        for (int i = 0; i < ((d < 0) ? -d : d); i++) begin
            if (d > 0) press(1'b0, 1'b1, 1'b0);
            else       press(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic check_commit(input string nm, input int h, input int m, input int s);
        chk({nm, " strobe count"}, q.size(), 3);
        if (q.size() == 3) begin
            chk({nm, " strobe0 imp"}, int'(q[0].imp), 4);
            chk({nm, " strobe0 hour"}, int'(q[0].data), h);
            chk({nm, " strobe1 imp"}, int'(q[1].imp), 2);
            chk({nm, " strobe1 min"}, int'(q[1].data), m);
            chk({nm, " strobe2 imp"}, int'(q[2].imp), 1);
            chk({nm, " strobe2 sec"}, int'(q[2].data), s);
            chk({nm, " strobes consecutive"},
                int'((q[1].cyc - q[0].cyc == 1) && (q[2].cyc - q[1].cyc == 1)), 1);
            chk({nm, " run_en low in commit"}, int'(q[0].run | q[1].run | q[2].run), 0);
        end
        chk({nm, " run_en after commit"}, run_after, 1);
        q.delete();
        run_after = -1;
    endtask

    // Reference step: clamp to max, then modular add over 0..max.
    function automatic int mstep(input int v, input int mx, input int dir);
        int x;
        x = (v > mx) ? mx : v;
        return (x + dir + mx + 1) % (mx + 1);
    endfunction

    function automatic int fmax(input int fld);
        return (fld == 1) ? 23 : 59;
    endfunction

    function automatic int rv(input int mx);
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255));
        return int'($urandom_range(0, mx));
    endfunction

    initial begin
        int   badint, nchg, lastc, waited, found;
        logic lastb;
        int   e[3];
        int   fld, k, r;

        tbl[0] = '{8'd12, 8'd34, 8'd56, 13, -35, 0, 8'd1, 8'd59, 8'd56};
        tbl[1] = '{8'd0, 8'd0, 8'd59, -1, 0, 1, 8'd23, 8'd0, 8'd0};
        tbl[2] = '{8'd0, 8'd0, 8'd0, 0, 0, -1, 8'd0, 8'd0, 8'd59};
        tbl[3] = '{8'd30, 8'd70, 8'd99, 1, -1, 1, 8'd0, 8'd58, 8'd0};
        tbl[4] = '{8'd23, 8'd59, 8'd59, 1, 1, 1, 8'd0, 8'd0, 8'd0};
        tbl[5] = '{8'd5, 8'd0, 8'd30, -6, 61, -31, 8'd23, 8'd1, 8'd59};
        tbl[6] = '{8'd255, 8'd255, 8'd255, -1, -1, -1, 8'd22, 8'd58, 8'd58};

        // reset values
        tick(3);
        chk("reset setup_imp", int'(setup_imp), 0);
        chk("reset setup_data", int'(setup_data), 0);
        chk("reset run_en", int'(run_en), 1);
        chk("reset edit_field", int'(edit_field), 0);
        chk("reset blink", int'(blink), 0);
        reset = 1'b1;
        tick(3);
        chk("post-reset run_en", int'(run_en), 1);
        chk("post-reset edit_field", int'(edit_field), 0);

        // bouncing mode button: exactly one entry
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn_mode = 1'b1; tick(2);
            btn_mode = 1'b0; tick(2);
        end
        btn_mode = 1'b1; tick(10);
        btn_mode = 1'b0; tick(10);
        chk("bounce run_en falls", run_falls, 1);
        chk("bounce edit_field", int'(edit_field), 1);
        chk("bounce run_en", int'(run_en), 0);

        // table-driven edit sessions
        do_reset();
        for (int v = 0; v < 7; v++) begin
            cur_hour = tbl[v].ch;
            cur_min  = tbl[v].cm;
            cur_sec  = tbl[v].cs;
            press(1'b1, 1'b0, 1'b0);
            chk("vec field hour", int'(edit_field), 1);
            chk("vec run_en held", int'(run_en), 0);
            cur_hour = ~tbl[v].ch;
            cur_min  = ~tbl[v].cm;
            cur_sec  = ~tbl[v].cs;
            steps(tbl[v].dh);
            press(1'b1, 1'b0, 1'b0);
            chk("vec field min", int'(edit_field), 2);
            steps(tbl[v].dm);
            press(1'b1, 1'b0, 1'b0);
            chk("vec field sec", int'(edit_field), 3);
            steps(tbl[v].ds);
            press(1'b1, 1'b0, 1'b0);
            check_commit($sformatf("vec%0d", v), int'(tbl[v].eh), int'(tbl[v].em), int'(tbl[v].es));
            chk("vec idle field", int'(edit_field), 0);
        end

        // up/down in idle are ignored
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("idle updown field", int'(edit_field), 0);
        chk("idle updown strobes", q.size(), 0);
        chk("idle updown run_en", int'(run_en), 1);

        // auto-repeat: accepted level high 33 cycles -> press + repeats at +20,+25,+30
        do_reset();
        cur_hour = 8'd0; cur_min = 8'd10; cur_sec = 8'd0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("repeat field min", int'(edit_field), 2);
        btn_up = 1'b1;
        tick(33);
        btn_up = 1'b0;
        tick(40);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check_commit("repeat", 0, 14, 0);

        // timeout and blink
        do_reset();
        cur_hour = 8'd3; cur_min = 8'd4; cur_sec = 8'd5;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        badint = 0; nchg = 0; lastc = -1; lastb = blink;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (blink != lastb) begin
                if (lastc >= 0 && i - lastc != int'(BLK)) badint++;
                lastc = i;
                nchg++;
                lastb = blink;
            end
        end
        chk("blink interval errors", badint, 0);
        chk("blink toggled", int'(nchg >= 10), 1);
        chk("pre-timeout field", int'(edit_field), 1);
        waited = 100;
        for (int j = 0; j < 200 && edit_field != 2'd0; j++) begin
            tick(1);
            waited++;
        end
        chk("timeout field", int'(edit_field), 0);
        chk("timeout delay in range", int'(waited >= 188 && waited <= 196), 1);
        chk("timeout strobes", q.size(), 0);
        chk("timeout run_en", int'(run_en), 1);
        chk("timeout blink", int'(blink), 0);

        // reset in the middle of the commit sequence
        do_reset();
        cur_hour = 8'd1; cur_min = 8'd2; cur_sec = 8'd3;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        btn_mode = 1'b1;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (setup_imp == 3'b010) begin
                found = 1;
                break;
            end
        end
        chk("midcommit min strobe seen", found, 1);
        reset    = 1'b0;
        btn_mode = 1'b0;
        #1;
        chk("midcommit async setup_imp", int'(setup_imp), 0);
        chk("midcommit async run_en", int'(run_en), 1);
        chk("midcommit async edit_field", int'(edit_field), 0);
        tick(3);
        reset = 1'b1;
        q.delete();
        tick(20);
        chk("midcommit no later strobes", q.size(), 0);

        // randomized sessions against the reference model
        do_reset();
        for (int s = 0; s < 8; s++) begin
            cur_hour = 8'(rv(23));
            cur_min  = 8'(rv(59));
            cur_sec  = 8'(rv(59));
            e[0] = int'(cur_hour);
            e[1] = int'(cur_min);
            e[2] = int'(cur_sec);
            press(1'b1, 1'b0, 1'b0);
            fld = 1;
            chk("rand entry field", int'(edit_field), 1);
            cur_hour = 8'($urandom);
            cur_min  = 8'($urandom);
            cur_sec  = 8'($urandom);
            k = 0;
            while (fld != 0) begin
                r = (k > 30) ? 8 : int'($urandom_range(0, 9));
                k++;
                if (r < 4) begin
                    press(1'b0, 1'b1, 1'b0);
                    e[fld-1] = mstep(e[fld-1], fmax(fld), 1);
                end else if (r < 7) begin
                    press(1'b0, 1'b0, 1'b1);
                    e[fld-1] = mstep(e[fld-1], fmax(fld), -1);
                end else if (r == 7) begin
                    press(1'b0, 1'b1, 1'b1);
                end else begin
                    press(1'b1, r == 8, r == 9);
                    if (fld == 3) begin
                        check_commit($sformatf("rand%0d", s), e[0], e[1], e[2]);
                        fld = 0;
                    end else begin
                        fld++;
                        chk("rand field advance", int'(edit_field), fld);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
